// File: rtl/lif_neuron_param.sv
// rtl/lif_neuron_param.sv - parameterised leaky integrate-and-fire neuron, one tick per start
// Integrates NUM_AXONS handshaked axon events, applies leak, then saturates and fires.
module lif_neuron_param #(
   parameter int  NUM_AXONS    = 256,
   parameter int  POT_W        = 8,
   parameter int  WEIGHT_TYPES = 4,
   parameter int  RESET_MODE   = 0,
   localparam int SEL_W        = (WEIGHT_TYPES > 1) ? $clog2(WEIGHT_TYPES) : 1
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            start_i,
   input  logic                            clear_i,
   input  logic signed [POT_W-1:0]         voltage_potential_i,
   input  logic signed [POT_W-1:0]         pos_threshold_i,
   input  logic signed [POT_W-1:0]         neg_threshold_i,
   input  logic signed [POT_W-1:0]         pos_reset_i,
   input  logic signed [POT_W-1:0]         neg_reset_i,
   input  logic signed [POT_W-1:0]         leak_value_i,
   input  logic [WEIGHT_TYPES*POT_W-1:0]   weights_i,
   input  logic                            axon_valid_i,
   input  logic                            axon_spike_i,
   input  logic [SEL_W-1:0]                weight_select_i,
   output logic                            axon_ready_o,
   output logic                            busy_o,
   output logic signed [POT_W-1:0]         new_potential_o,
   output logic                            spike_o,
   output logic                            done_o
);

   localparam int CNT_W = $clog2(NUM_AXONS);
   // Two guard bits above the worst-case sum of NUM_AXONS weights plus start and leak.
   localparam int ACC_W = POT_W + CNT_W + 2;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_AXONS - 1);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_INTEGRATE = 2'd1;
   localparam logic [1:0] S_LEAK      = 2'd2;
   localparam logic [1:0] S_FIRE      = 2'd3;

   logic [1:0]              state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic signed [POT_W-1:0] pot_q, pot_d;
   logic                    spike_q, spike_d;
   logic                    done_q, done_d;

   logic signed [POT_W-1:0] weight_sel;
   logic [ACC_W-POT_W:0]    acc_hi;
   logic signed [POT_W-1:0] sat;
   logic [POT_W:0]          diff;
   logic signed [POT_W-1:0] diff_sat;

   // Selects beyond WEIGHT_TYPES-1 match no entry and contribute zero.
   always_comb begin
      weight_sel = '0;
      for (int k = 0; k < WEIGHT_TYPES; k++) begin
         if (weight_select_i == SEL_W'(k)) begin
            weight_sel = weights_i[k*POT_W +: POT_W];
         end
      end
   end

   // The accumulator fits POT_W bits only when every bit above the POT_W sign bit agrees.
   always_comb begin
      acc_hi = acc_q[ACC_W-1:POT_W-1];
      if (acc_hi == '0 || acc_hi == '1) begin
         sat = acc_q[POT_W-1:0];
      end else if (acc_q[ACC_W-1]) begin
         sat = {1'b1, {(POT_W-1){1'b0}}};
      end else begin
         sat = {1'b0, {(POT_W-1){1'b1}}};
      end
      diff = {sat[POT_W-1], sat} - {pos_threshold_i[POT_W-1], pos_threshold_i};
      if (diff[POT_W] == diff[POT_W-1]) begin
         diff_sat = diff[POT_W-1:0];
      end else if (diff[POT_W]) begin
         diff_sat = {1'b1, {(POT_W-1){1'b0}}};
      end else begin
         diff_sat = {1'b0, {(POT_W-1){1'b1}}};
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      pot_d   = pot_q;
      spike_d = spike_q;
      done_d  = 1'b0;
      if (clear_i) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  acc_d   = {{(ACC_W-POT_W){voltage_potential_i[POT_W-1]}}, voltage_potential_i};
                  cnt_d   = '0;
                  state_d = S_INTEGRATE;
               end
            end
            S_INTEGRATE: begin
               if (axon_valid_i) begin
                  cnt_d = cnt_q + 1'b1;
                  if (axon_spike_i) begin
                     acc_d = acc_q + {{(ACC_W-POT_W){weight_sel[POT_W-1]}}, weight_sel};
                  end
                  if (cnt_q == LAST_CNT) begin
                     cnt_d   = '0;
                     state_d = S_LEAK;
                  end
               end
            end
            S_LEAK: begin
               acc_d   = acc_q + {{(ACC_W-POT_W){leak_value_i[POT_W-1]}}, leak_value_i};
               state_d = S_FIRE;
            end
            S_FIRE: begin
               done_d  = 1'b1;
               state_d = S_IDLE;
               if (sat >= pos_threshold_i) begin
                  spike_d = 1'b1;
                  pot_d   = (RESET_MODE == 1) ? diff_sat : pos_reset_i;
               end else if (sat < neg_threshold_i) begin
                  spike_d = 1'b0;
                  pot_d   = neg_reset_i;
               end else begin
                  spike_d = 1'b0;
                  pot_d   = sat;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         pot_q   <= '0;
         spike_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         pot_q   <= pot_d;
         spike_q <= spike_d;
         done_q  <= done_d;
      end
   end

   assign axon_ready_o    = (state_q == S_INTEGRATE);
   assign busy_o          = (state_q != S_IDLE);
   assign new_potential_o = pot_q;
   assign spike_o         = spike_q;
   assign done_o          = done_q;

endmodule

// File: tb/tb_lif_neuron_param.sv
// tb/tb_lif_neuron_param.sv - directed bench for lif_neuron_param
// Instance a: defaults (reset-to-value); instance b: subtract-threshold, 5 weight types.
module tb_lif_neuron_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset_n, start_i, clear_i, axon_valid_i, axon_spike_i;
   logic signed [7:0] v_i, pthr_i, nthr_i, preset_i, nreset_i, leak_i;
   logic [31:0]       weights_a;
   logic [7:0]        w4;
   logic [39:0]       weights_b;
   logic [2:0]        sel_b;
   logic [1:0]        sel_a;

   logic              rdy_a, busy_a, spk_a, done_a;
   logic              rdy_b, busy_b, spk_b, done_b;
   logic signed [7:0] pot_a, pot_b;

   assign weights_b = {w4, weights_a};
   assign sel_a     = sel_b[1:0];

   lif_neuron_param dut_a (
      .clk(clk), .reset_n(reset_n), .start_i(start_i), .clear_i(clear_i),
      .voltage_potential_i(v_i), .pos_threshold_i(pthr_i), .neg_threshold_i(nthr_i),
      .pos_reset_i(preset_i), .neg_reset_i(nreset_i), .leak_value_i(leak_i),
      .weights_i(weights_a), .axon_valid_i(axon_valid_i), .axon_spike_i(axon_spike_i),
      .weight_select_i(sel_a), .axon_ready_o(rdy_a), .busy_o(busy_a),
      .new_potential_o(pot_a), .spike_o(spk_a), .done_o(done_a)
   );

   lif_neuron_param #(.WEIGHT_TYPES(5), .RESET_MODE(1)) dut_b (
      .clk(clk), .reset_n(reset_n), .start_i(start_i), .clear_i(clear_i),
      .voltage_potential_i(v_i), .pos_threshold_i(pthr_i), .neg_threshold_i(nthr_i),
      .pos_reset_i(preset_i), .neg_reset_i(nreset_i), .leak_value_i(leak_i),
      .weights_i(weights_b), .axon_valid_i(axon_valid_i), .axon_spike_i(axon_spike_i),
      .weight_select_i(sel_b), .axon_ready_o(rdy_b), .busy_o(busy_b),
      .new_potential_o(pot_b), .spike_o(spk_b), .done_o(done_b)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input int v, input int pt, input int nt, input int lk);
      v_i = 8'(v); pthr_i = 8'(pt); nthr_i = 8'(nt); leak_i = 8'(lk);
   endtask

   task automatic start_tick();
      start_i = 1'b1;
      step();
      start_i = 1'b0;
   endtask

   task automatic feed(input int n, input logic spk, input logic [2:0] sel);
      for (int i = 0; i < n; i++) begin
         axon_valid_i = 1'b1; axon_spike_i = spk; sel_b = sel;
         step();
      end
      axon_valid_i = 1'b0; axon_spike_i = 1'b0;
   endtask

   // Entered just after the last handshake edge; done must rise exactly two edges later.
   task automatic finish_tick(input string tag, input int ea, input int sa, input int eb, input int sb);
      check({tag, "_done_lat1"}, int'(done_b), 0);
      step();
      check({tag, "_done_lat2"}, int'(done_b), 0);
      step();
      check({tag, "_done_b"}, int'(done_b), 1);
      check({tag, "_done_a"}, int'(done_a), 1);
      check({tag, "_pot_a"}, int'(pot_a), ea);
      check({tag, "_spk_a"}, int'(spk_a), sa);
      check({tag, "_pot_b"}, int'(pot_b), eb);
      check({tag, "_spk_b"}, int'(spk_b), sb);
   endtask

   initial begin
      int hs, cyc, seen;
      reset_n = 1'b0; start_i = 1'b0; clear_i = 1'b0;
      axon_valid_i = 1'b0; axon_spike_i = 1'b0; sel_b = 3'd0;
      preset_i = 8'sd5; nreset_i = -8'sd10; w4 = 8'd7;
      weights_a = {8'd4, 8'd3, 8'd2, 8'd1};
      cfg(10, 100, -50, -2);
      step(); step();
      check("rst_pot", int'(pot_a), 0);
      check("rst_spk", int'(spk_a), 0);
      check("rst_done", int'(done_a), 0);
      check("rst_rdy", int'(rdy_a), 0);
      check("rst_busy", int'(busy_b), 0);
      reset_n = 1'b1;

      // 10 + 256*1 - 2 = 264 -> clamps to 127; b: 127 - 100 = 27
      start_tick();
      check("int_rdy", int'(rdy_a), 1);
      check("int_busy", int'(busy_a), 1);
      feed(256, 1'b1, 3'd0);
      check("leak_rdy", int'(rdy_a), 0);
      finish_tick("sat_pos", 5, 1, 27, 1);
      step();
      check("done_pulse", int'(done_a), 0);
      check("hold_pot", int'(pot_a), 5);

      // -256 clamps to -128 < -50 -> neg_reset
      weights_a = {8'd4, 8'd3, 8'd2, 8'hFF};
      cfg(0, 100, -50, 0);
      start_tick(); feed(256, 1'b1, 3'd0);
      finish_tick("neg_floor", -10, 0, -10, 0);

      // 60 + 50 = 110 >= 100; b: 110 - 100 = 10
      weights_a = {8'd4, 8'd50, 8'd2, 8'd1};
      cfg(60, 100, -50, 0);
      start_tick(); feed(1, 1'b1, 3'd2); feed(255, 1'b0, 3'd2);
      finish_tick("sub_thr", 5, 1, 10, 1);

      // 10 + 3*2 - 2 = 14, between thresholds
      weights_a = {8'd4, 8'd3, 8'd2, 8'd1};
      cfg(10, 100, -50, -2);
      start_tick(); feed(3, 1'b1, 3'd1); feed(253, 1'b0, 3'd1);
      finish_tick("mid", 14, 0, 14, 0);

      // Equality with pos threshold fires
      cfg(50, 50, -50, 0);
      start_tick(); feed(256, 1'b0, 3'd0);
      finish_tick("eq_pos", 5, 1, 0, 1);

      // Equality with neg threshold does not floor
      cfg(-50, 100, -50, 0);
      start_tick(); feed(256, 1'b0, 3'd0);
      finish_tick("eq_neg", -50, 0, -50, 0);

      // b: 127 - (-100) = 227 saturates to 127
      cfg(127, -100, -128, 0);
      start_tick(); feed(256, 1'b0, 3'd0);
      finish_tick("sub_clamp", 5, 1, 127, 1);

      // Random valid, out-of-range select 5 on b adds nothing
      cfg(20, 100, -50, 0);
      start_tick();
      hs = 0; cyc = 0;
      while (!done_b && cyc < 3000) begin
         axon_valid_i = 1'($urandom_range(0, 1));
         axon_spike_i = 1'($urandom_range(0, 1));
         sel_b = 3'd5;
         if (axon_valid_i && rdy_b) hs++;
         step();
         cyc++;
      end
      axon_valid_i = 1'b0;
      check("rand_hs", hs, 256);
      check("rand_done", int'(done_b), 1);
      check("rand_pot_b", int'(pot_b), 20);
      check("rand_spk_b", int'(spk_b), 0);
      step();

      // Clear at axon 100 overrides the handshake; no done, outputs held
      cfg(10, 100, -50, -2);
      start_tick(); feed(100, 1'b1, 3'd0);
      clear_i = 1'b1; axon_valid_i = 1'b1; axon_spike_i = 1'b1;
      step();
      clear_i = 1'b0; axon_valid_i = 1'b0;
      check("clr_busy", int'(busy_b), 0);
      check("clr_rdy", int'(rdy_b), 0);
      check("clr_pot_b", int'(pot_b), 20);
      check("clr_spk_b", int'(spk_b), 0);
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         if (done_a || done_b) seen = 1;
         step();
      end
      check("clr_no_done", seen, 0);

      // Async reset at axon 50 of the next tick
      start_tick(); feed(50, 1'b1, 3'd0);
      #2 reset_n = 1'b0;
      #1;
      check("arst_pot_b", int'(pot_b), 0);
      check("arst_busy", int'(busy_b), 0);
      check("arst_rdy", int'(rdy_b), 0);
      seen = 0;
      for (int i = 0; i < 3; i++) begin
         if (done_a || done_b) seen = 1;
         step();
      end
      reset_n = 1'b1; start_i = 1'b1;
      step();
      start_i = 1'b0;
      check("rel_start", int'(busy_b), 1);
      check("arst_no_done", seen + int'(done_a) + int'(done_b), 0);

      // Clean tick after reset
      feed(256, 1'b1, 3'd0);
      finish_tick("clean", 5, 1, 27, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lif_neuron_param.md
LIF_NEURON_PARAM -- requirements
Module: lif_neuron_param

Interface
REQ-001 Parameter NUM_AXONS, default 256: axon events integrated per tick (>=2).
REQ-002 Parameter POT_W, default 8: width of all signed potential/weight/threshold values.
REQ-003 Parameter WEIGHT_TYPES, default 4: number of selectable weights; SEL_W = max(1, clog2(WEIGHT_TYPES)).
REQ-004 Parameter RESET_MODE, default 0: 0 = reset-to-value, 1 = subtract-threshold.
REQ-005 clk  in  1  clock; all state on rising edge.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 start_i  in  1  begin tick; sampled only in IDLE.
REQ-008 clear_i  in  1  synchronous abort of current tick.
REQ-009 voltage_potential_i  in  POT_W signed  starting potential; loaded at start.
REQ-010 pos_threshold_i / neg_threshold_i  in  POT_W signed each  fire / floor thresholds.
REQ-011 pos_reset_i / neg_reset_i  in  POT_W signed each  post-fire / post-floor values.
REQ-012 leak_value_i  in  POT_W signed  added once per tick.
REQ-013 weights_i  in  WEIGHT_TYPES*POT_W  packed signed weights, type k at bits [k*POT_W +: POT_W].
REQ-014 axon_valid_i  in  1  axon event present.
REQ-015 axon_spike_i  in  1  axon fired (1 = add weight, 0 = add nothing).
REQ-016 weight_select_i  in  SEL_W  weight type for current axon.
REQ-017 axon_ready_o  out  1  block accepts an axon event.
REQ-018 busy_o  out  1  state != IDLE.
REQ-019 new_potential_o  out  POT_W signed  registered potential after tick.
REQ-020 spike_o  out  1  registered fire flag for last tick.
REQ-021 done_o  out  1  one-cycle pulse: outputs updated.

Function
REQ-022 FSM states IDLE, INTEGRATE, LEAK, FIRE; one-hot or binary encoding at implementer's choice.
REQ-023 IDLE: start_i=1 -> acc = sign-extended voltage_potential_i, axon count = 0, next INTEGRATE; else stay.
REQ-024 Accumulator signed, width POT_W + clog2(NUM_AXONS) + 2; no internal overflow possible.
REQ-025 axon_ready_o = 1 only in INTEGRATE; handshake = axon_valid_i && axon_ready_o.
REQ-026 Each handshake: count increments; if axon_spike_i=1 acc += weights_i[weight_select_i]; select >= WEIGHT_TYPES adds 0.
REQ-027 Handshake with count == NUM_AXONS-1 -> count wraps to 0, next LEAK; no further axon accepted this tick.
REQ-028 axon_valid_i low in INTEGRATE -> stall, no state change; no timeout.
REQ-029 LEAK (one cycle): acc += sign-extended leak_value_i; next FIRE.
REQ-030 FIRE (one cycle): sat = acc clamped to [-2^(POT_W-1), 2^(POT_W-1)-1].
REQ-031 FIRE: sat >= pos_threshold_i -> spike_o=1; new_potential_o = pos_reset_i (RESET_MODE 0) or saturated sat - pos_threshold_i (RESET_MODE 1).
REQ-032 FIRE: else sat < neg_threshold_i -> spike_o=0, new_potential_o = neg_reset_i.
REQ-033 FIRE: else spike_o=0, new_potential_o = sat.
REQ-034 FIRE: done_o=1 same edge outputs update; next IDLE; latency last handshake -> done_o = 2 cycles.
REQ-035 new_potential_o and spike_o hold value between done_o pulses.
REQ-036 clear_i=1 in any state -> next IDLE, count=0, no done_o, outputs unchanged; clear_i overrides start_i and handshake in same cycle.
REQ-037 start_i outside IDLE ignored; start_i in IDLE cycle after FIRE accepted (back-to-back ticks, 1 idle cycle min).
REQ-038 All comparisons signed at POT_W width.

Reset
REQ-039 reset_n low -> state IDLE, acc=0, count=0, new_potential_o=0, spike_o=0, done_o=0, axon_ready_o=0, busy_o=0.
REQ-040 reset_n low mid-tick -> tick discarded; no done_o after release.
REQ-041 reset_n deassertion synchronised externally; first start_i honoured first edge after release.

Verification
REQ-042 Defaults, V=10, all 256 axons spike with weight 1 (sel 0), leak -2, pos_thr 100 -> sat 264 clamps to 127, spike_o=1, new_potential_o=pos_reset_i, done_o 2 cycles after last handshake.
REQ-043 V=0, weights {-1,2,3,4}, 256 axons spike sel 0, leak 0, neg_thr -50, neg_reset -10 -> spike_o=0, new_potential_o=-10.
REQ-044 RESET_MODE=1, V=60, one axon spike weight 50, leak 0, pos_thr 100 -> spike_o=1, new_potential_o=10.
REQ-045 axon_valid_i toggled randomly, sel=5 on spiking axons, V=20, leak 0 -> exactly 256 handshakes, new_potential_o=20, spike_o=0.
REQ-046 clear_i at axon 100, then reset_n low at axon 50 of next tick -> no done_o either tick, outputs per REQ-036/REQ-039, next clean tick correct.
